imem_access_ctrl: RTL and testbench

//  Owns the single port of the instruction memory (prgrom, 1-cycle registered read) and shares it

---
 rtl/imem_access_ctrl.sv | 151 +++++++++++++++
 tb/tb_imem_access_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_access_ctrl.sv
// ============================================================================
// Module   : imem_access_ctrl
// Brief    : Arbitrates the single instruction-memory port between CPU fetch
//            and a UART program loader, with boot/flush sequencing.
// Revision : 1.0
// ============================================================================
`default_nettype none

module imem_access_ctrl #(
    parameter int ADDR_WIDTH   = 14,
    parameter int DATA_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int LOAD_TIMEOUT = 4096
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           fetch_addr_i,
    output logic [DATA_WIDTH-1:0] fetch_data_o,
    output logic                  fetch_valid_o,
    output logic                  cpu_stall_o,
    output logic                  cpu_reset_req_o,
    input  logic                  ld_start_i,
    input  logic                  ld_wr_en_i,
    input  logic [ADDR_WIDTH-1:0] ld_addr_i,
    input  logic [DATA_WIDTH-1:0] ld_data_i,
    input  logic                  ld_done_i,
    output logic                  ld_ack_o,
    output logic                  load_busy_o,
    output logic [ADDR_WIDTH:0]   load_count_o,
    output logic                  load_error_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  mem_we_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int FLUSH_W = $clog2(FLUSH_CYCLES) + 1;
    localparam int TMO_W   = $clog2(LOAD_TIMEOUT) + 1;
    localparam logic [FLUSH_W-1:0]  FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);
    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(LOAD_TIMEOUT - 1);
    localparam logic [ADDR_WIDTH:0] COUNT_MAX  = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_LOAD  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [FLUSH_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                error_q, error_d;
    logic                ack_q;
    logic                valid_q;
    logic                w_write;
    logic                w_unused;

    assign w_unused = ^{fetch_addr_i[31:ADDR_WIDTH+2], fetch_addr_i[1:0]};

    always_comb begin
        state_d         = state_q;
        flush_cnt_d     = flush_cnt_q;
        tmo_d           = tmo_q;
        count_d         = count_q;
        error_d         = error_q;
        cpu_stall_o     = 1'b1;
        cpu_reset_req_o = 1'b1;
        load_busy_o     = 1'b0;
        mem_addr_o      = '0;
        w_write         = 1'b0;
        case (state_q)
            S_BOOT, S_FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d     = S_RUN;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                cpu_stall_o     = 1'b0;
                cpu_reset_req_o = 1'b0;
                mem_addr_o      = fetch_addr_i[ADDR_WIDTH+1:2];
                if (ld_start_i) begin
                    state_d = S_LOAD;
                    count_d = '0;
                    error_d = 1'b0;
                    tmo_d   = '0;
                end
            end
            S_LOAD: begin
                cpu_reset_req_o = 1'b0;
                load_busy_o     = 1'b1;
                mem_addr_o      = ld_addr_i;
                w_write         = ld_wr_en_i;
                if (ld_wr_en_i) begin
                    tmo_d = '0;
                    if (count_q != COUNT_MAX) begin
                        count_d = count_q + 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
                // A completed load takes precedence over a coincident timeout.
                if (ld_done_i) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = '0;
                end else if (!ld_wr_en_i && tmo_q == TMO_LAST) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = '0;
                    error_d     = 1'b1;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_BOOT;
            flush_cnt_q <= '0;
            tmo_q       <= '0;
            count_q     <= '0;
            error_q     <= 1'b0;
            ack_q       <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            tmo_q       <= tmo_d;
            count_q     <= count_d;
            error_q     <= error_d;
            ack_q       <= w_write;
            valid_q     <= (state_q == S_RUN);
        end
    end

    // Write is blocked combinationally so the reset edge itself cannot corrupt memory.
    assign mem_we_o      = w_write & ~rst_i;
    assign mem_wdata_o   = ld_data_i;
    assign fetch_valid_o = valid_q;
    assign fetch_data_o  = valid_q ? mem_rdata_i : '0;
    assign ld_ack_o      = ack_q;
    assign load_count_o  = count_q;
    assign load_error_o  = error_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_access_ctrl.sv
// ============================================================================
// Module   : tb_imem_access_ctrl
// Brief    : Self-checking bench for imem_access_ctrl with a ROM model and a
//            reference image of the expected program memory contents.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_imem_access_ctrl;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int FC = 2;
    localparam int LT = 8;
    localparam int NW = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   fetch_addr;
    logic [DW-1:0] fetch_data;
    logic          fetch_valid, cpu_stall, cpu_reset_req;
    logic          ld_start, ld_wr_en, ld_done;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_ack, load_busy, load_error;
    logic [AW:0]   load_count;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_we;

    int vectors    = 0;
    int miscompares = 0;
    int model_writes;

    logic [DW-1:0] rom     [NW];
    logic [DW-1:0] exp_mem [NW];

    always #5 clk = ~clk;

    imem_access_ctrl #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .FLUSH_CYCLES(FC),
        .LOAD_TIMEOUT(LT)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .fetch_addr_i   (fetch_addr),
        .fetch_data_o   (fetch_data),
        .fetch_valid_o  (fetch_valid),
        .cpu_stall_o    (cpu_stall),
        .cpu_reset_req_o(cpu_reset_req),
        .ld_start_i     (ld_start),
        .ld_wr_en_i     (ld_wr_en),
        .ld_addr_i      (ld_addr),
        .ld_data_i      (ld_data),
        .ld_done_i      (ld_done),
        .ld_ack_o       (ld_ack),
        .load_busy_o    (load_busy),
        .load_count_o   (load_count),
        .load_error_o   (load_error),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_we_o       (mem_we),
        .mem_rdata_i    (mem_rdata)
    );

    // Single-port ROM with one-cycle registered read.
    always @(posedge clk) begin
        if (mem_we) rom[mem_addr] <= mem_wdata;
        mem_rdata <= rom[mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    function automatic logic [AW:0] exp_count();
        return (model_writes > NW) ? (AW+1)'(NW) : (AW+1)'(model_writes);
    endfunction

    task automatic count_flush(output int n);
        n = 0;
        while (cpu_reset_req === 1'b1 && n < 12) begin
            chk("flush_fvalid", fetch_valid, 0);
            chk("flush_stall", cpu_stall, 1);
            n++;
            tick;
        end
    endtask

    task automatic start_load;
        ld_start = 1'b1;
        settle;
        chk("pre_load_busy", load_busy, 0);
        tick;
        ld_start = 1'b0;
        model_writes = 0;
        chk("load_busy", load_busy, 1);
        chk("load_stall", cpu_stall, 1);
        chk("load_rreq", cpu_reset_req, 0);
        chk("load_cnt_clr", load_count, 0);
    endtask

    task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ld_wr_en = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        settle;
        chk("we_load", mem_we, 1);
        chk("waddr", mem_addr, a);
        chk("wdata", mem_wdata, d);
        tick;
        ld_wr_en = 1'b0;
        exp_mem[a] = d;
        model_writes++;
        chk("ack", ld_ack, 1);
        chk("cnt_run", load_count, exp_count());
    endtask

    task automatic idle_load;
        settle;
        chk("we_idle", mem_we, 0);
        tick;
        chk("ack_idle", ld_ack, 0);
    endtask

    task automatic finish_load;
        int n;
        ld_done = 1'b1;
        settle;
        tick;
        ld_done = 1'b0;
        chk("done_busy", load_busy, 0);
        chk("done_rreq", cpu_reset_req, 1);
        chk("done_cnt", load_count, exp_count());
        count_flush(n);
        chk("flush_len", n, FC);
        chk("run_stall", cpu_stall, 0);
        chk("first_run_fvalid", fetch_valid, 0);
        chk("first_run_fdata", fetch_data, 0);
    endtask

    task automatic fetch_chk(input logic [31:0] pc);
        logic [AW-1:0] idx;
        idx = pc[AW+1:2];
        fetch_addr = pc;
        settle;
        chk("fetch_maddr", mem_addr, idx);
        chk("fetch_we", mem_we, 0);
        tick;
        chk("fetch_valid", fetch_valid, 1);
        chk("fetch_data", fetch_data, exp_mem[idx]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1);
    end

    initial begin
        int n;
        logic [DW-1:0] old9;
        rst = 1'b1; fetch_addr = 32'h40;
        ld_start = 1'b0; ld_wr_en = 1'b1; ld_done = 1'b0;
        ld_addr = '0; ld_data = '0;
        model_writes = 0;

        // Reset state held for three cycles
        repeat (3) begin
            tick;
            chk("rst_stall", cpu_stall, 1);
            chk("rst_rreq", cpu_reset_req, 1);
            chk("rst_fvalid", fetch_valid, 0);
            chk("rst_ack", ld_ack, 0);
            chk("rst_cnt", load_count, 0);
            chk("rst_err", load_error, 0);
            chk("rst_we", mem_we, 0);
            chk("rst_maddr", mem_addr, 0);
        end
        rst = 1'b0; ld_wr_en = 1'b0;
        count_flush(n);
        chk("boot_len", n, FC);
        fetch_addr = 32'h8;
        settle;
        chk("boot_fetch_maddr", mem_addr, 2);
        tick;
        chk("boot_fetch_valid", fetch_valid, 1);
        chk("boot_fetch_data", fetch_data, mem_rdata);

        // Three-word load; a mid-load ld_start must not restart the count
        start_load;
        load_word(0, 32'hA);
        ld_start = 1'b1;
        load_word(1, 32'hB);
        ld_start = 1'b0;
        load_word(2, 32'hC);
        finish_load;
        chk("three_cnt", load_count, 3);
        fetch_chk(32'h0);

        // Write strobes outside LOAD are ignored
        ld_addr = 2; ld_data = 32'hDEAD; ld_wr_en = 1'b1;
        settle;
        chk("run_we", mem_we, 0);
        tick;
        ld_wr_en = 1'b0;
        chk("run_ack", ld_ack, 0);
        chk("run_cnt", load_count, 3);
        fetch_chk(32'h8);
        start_load;
        load_word(3, 32'h33);
        ld_done = 1'b1;
        settle;
        tick;
        ld_done = 1'b0;
        ld_addr = 1; ld_data = 32'hBEEF; ld_wr_en = 1'b1;
        settle;
        chk("flush_we", mem_we, 0);
        tick;
        ld_wr_en = 1'b0;
        chk("flush_ack", ld_ack, 0);
        chk("flush_cnt", load_count, 1);
        count_flush(n);
        chk("flush_tail_len", n, FC - 1);
        fetch_chk(32'h4);

        // Simultaneous write and done
        start_load;
        ld_wr_en = 1'b1; ld_done = 1'b1; ld_addr = 5; ld_data = 32'h1234;
        settle;
        chk("wd_we", mem_we, 1);
        tick;
        ld_wr_en = 1'b0; ld_done = 1'b0;
        exp_mem[5] = 32'h1234;
        chk("wd_rreq", cpu_reset_req, 1);
        chk("wd_busy", load_busy, 0);
        chk("wd_cnt", load_count, 1);
        chk("wd_ack", ld_ack, 1);
        count_flush(n);
        chk("wd_flush_len", n, FC);
        fetch_chk(32'h14);

        // Fill the whole memory, overrunning so the count saturates
        start_load;
        for (int i = 0; i < NW + 6; i++) load_word(AW'(i), $urandom);
        finish_load;
        chk("sat_cnt", load_count, NW);

        // Timeout with no writes
        start_load;
        n = 0;
        while (load_busy === 1'b1 && n < 20) begin
            chk("tmo_we", mem_we, 0);
            n++;
            tick;
        end
        chk("tmo_len", n, LT);
        chk("tmo_err", load_error, 1);
        chk("tmo_rreq", cpu_reset_req, 1);
        count_flush(n);
        chk("tmo_flush_len", n, FC);
        chk("tmo_err_sticky", load_error, 1);
        ld_start = 1'b1;
        settle;
        chk("tmo_err_pre", load_error, 1);
        tick;
        ld_start = 1'b0;
        model_writes = 0;
        chk("tmo_err_clr", load_error, 0);
        finish_load;

        // Reset arriving together with a write in LOAD
        start_load;
        load_word(20, $urandom);
        old9 = exp_mem[9];
        rst = 1'b1; ld_wr_en = 1'b1; ld_addr = 9; ld_data = ~old9;
        settle;
        chk("rstld_we", mem_we, 0);
        tick;
        rst = 1'b0; ld_wr_en = 1'b0;
        chk("rstld_busy", load_busy, 0);
        chk("rstld_rreq", cpu_reset_req, 1);
        chk("rstld_cnt", load_count, 0);
        chk("rstld_ack", ld_ack, 0);
        chk("rstld_err", load_error, 0);
        count_flush(n);
        chk("rstld_boot_len", n, FC);
        fetch_chk(32'd36);
        fetch_chk(32'd80);

        // Randomized loads and fetches against the memory image
        for (int r = 0; r < 6; r++) begin
            int nw;
            start_load;
            nw = $urandom_range(1, 8);
            for (int w = 0; w < nw; w++) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    ld_start = 1'($urandom_range(0, 1));
                    idle_load;
                    ld_start = 1'b0;
                end
                load_word(AW'($urandom), $urandom);
            end
            finish_load;
            for (int f = 0; f < 12; f++) fetch_chk($urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
